// File: rtl/qslave_if.sv
// qslave_if: Q-bus receiver/transceiver control and device-side signals of
// the qslave block. The tri-state DAL stays a plain inout on the top module.
interface qslave_if;
  // Q-bus receivers / transceiver control
  logic        ZBS7;
  logic        ZWTBT;
  logic        RSYNC;
  logic        RDIN;
  logic        RDOUT;
  logic        DALtx;
  logic        DALst;
  logic        DALbe_L;
  logic        TRPLY;
  // device side
  logic [12:0] iADDR;
  logic        iBS7;
  logic        iREAD_MATCH;
  logic        iWRITE_MATCH;
  logic [15:0] iWDATA;
  logic        iWRITE;
  logic [1:0]  iWBYTE;
  logic [15:0] iRDATA;

  modport slave (
    input  ZBS7, ZWTBT, RSYNC, RDIN, RDOUT, iREAD_MATCH, iWRITE_MATCH, iRDATA,
    output DALtx, DALst, DALbe_L, TRPLY, iADDR, iBS7, iWDATA, iWRITE, iWBYTE
  );

  modport master (
    output ZBS7, ZWTBT, RSYNC, RDIN, RDOUT, iREAD_MATCH, iWRITE_MATCH, iRDATA,
    input  DALtx, DALst, DALbe_L, TRPLY, iADDR, iBS7, iWDATA, iWRITE, iWBYTE
  );
endinterface

// File: rtl/qslave.sv
// qslave: Q-bus slave front end. Latches the address phase, decodes through
// device match lines, and runs the DIN/DOUT/RPLY handshake for DATI, DATO(B)
// and DATIO(B) cycles. Optional byte-write enables: define QSLAVE_BYTE_EN.
module qslave (
  input  logic       qclk,
  input  logic       reset,
  inout  wire [21:0] ZDAL,
  qslave_if.slave    bus
);
  typedef enum logic [3:0] {
    IDLE, DECODE, WAITDS, RD_LATCH, RD_DRIVE, RD_REPLY, WR_REPLY, DS_END, NOMATCH
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  s1_q, s2_q;        // {SYNC, DIN, DOUT}
  logic        ssync, sdin, sdout;
  logic [1:0]  vld_pipe_q;
  logic        armed_q;
  logic [12:0] addr_q;
  logic        bs7_q;
  logic [15:0] rdata_q, wdata_q;
  logic        rd_q, wr_q;
  logic        match, rd_entry, wr_entry;
  logic        tx, st, be_l, trply;
  logic [1:0]  wbyte;

  assign {ssync, sdin, sdout} = s2_q;
  assign match = bus.iREAD_MATCH | bus.iWRITE_MATCH;

  // two-flop synchronizers on the receiver outputs
  always_ff @(posedge qclk or posedge reset)
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {bus.RSYNC, bus.RDIN, bus.RDOUT};
      s2_q <= s1_q;
    end

  // after reset the synchronizers read 0 regardless of the bus; only a SYNC
  // low seen once they carry real samples may arm the next decode
  always_ff @(posedge qclk or posedge reset)
    if (reset) begin
      vld_pipe_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], 1'b1};
      if (vld_pipe_q[1] && !ssync) armed_q <= 1'b1;
    end

`ifdef QSLAVE_BYTE_EN
  logic a0_q;
  // address phase capture; freezes once first-stage SYNC goes high
  always_ff @(posedge qclk or posedge reset)
    if (reset) begin
      addr_q <= '0;
      bs7_q  <= 1'b0;
      a0_q   <= 1'b0;
    end else if (!s1_q[2]) begin
      addr_q <= ZDAL[12:0];
      bs7_q  <= bus.ZBS7;
      a0_q   <= ZDAL[0];
    end
`else
  // address phase capture; freezes once first-stage SYNC goes high
  always_ff @(posedge qclk or posedge reset)
    if (reset) begin
      addr_q <= '0;
      bs7_q  <= 1'b0;
    end else if (!s1_q[2]) begin
      addr_q <= ZDAL[12:0];
      bs7_q  <= bus.ZBS7;
    end
`endif

  // state register
  always_ff @(posedge qclk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  // next state: SYNC low aborts from anywhere; DIN beats DOUT in WAITDS
  always_comb begin
    state_d = state_q;
    if (!ssync) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:     if (armed_q) state_d = DECODE;
        DECODE:   state_d = match ? WAITDS : NOMATCH;
        WAITDS:   if (sdin) begin
                    if (bus.iREAD_MATCH) state_d = RD_LATCH;
                  end else if (sdout && bus.iWRITE_MATCH) state_d = WR_REPLY;
        RD_LATCH: state_d = RD_DRIVE;
        RD_DRIVE: state_d = RD_REPLY;
        RD_REPLY: if (!sdin) state_d = DS_END;
        WR_REPLY: if (!sdout) state_d = DS_END;
        DS_END:   state_d = WAITDS;
        NOMATCH:  state_d = NOMATCH;
        default:  state_d = IDLE;
      endcase
    end
  end

  assign rd_entry = (state_q == WAITDS) && (state_d == RD_LATCH);
  assign wr_entry = (state_q == WAITDS) && (state_d == WR_REPLY);

  // read data latch, write data capture and one-cycle write strobe
  always_ff @(posedge qclk or posedge reset)
    if (reset) begin
      rdata_q <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      wr_q <= wr_entry;
      if (rd_entry) begin
        rdata_q <= bus.iRDATA;
        rd_q    <= 1'b1;
      end
      if (wr_entry) begin
        wdata_q <= ZDAL[15:0];
        rd_q    <= 1'b0;
      end
    end

`ifdef QSLAVE_BYTE_EN
  logic [1:0] wbyte_q;
  logic       unused_in;
  // byte lanes chosen from WTBT and address bit 0 at write entry
  always_ff @(posedge qclk or posedge reset)
    if (reset)         wbyte_q <= 2'b11;
    else if (wr_entry) wbyte_q <= bus.ZWTBT ? (a0_q ? 2'b10 : 2'b01) : 2'b11;
  assign wbyte     = wbyte_q;
  assign unused_in = ^ZDAL[21:16];
`else
  logic unused_in;
  assign wbyte     = 2'b11;
  assign unused_in = ^{bus.ZWTBT, ZDAL[21:16]};
`endif

  // Moore output decode; DS_END keeps read data on the bus one extra cycle
  always_comb begin
    tx    = 1'b0;
    st    = 1'b0;
    be_l  = 1'b1;
    trply = 1'b0;
    case (state_q)
      RD_LATCH: begin tx = 1'b1; st = 1'b1; end
      RD_DRIVE: begin tx = 1'b1; be_l = 1'b0; end
      RD_REPLY: begin tx = 1'b1; be_l = 1'b0; trply = 1'b1; end
      WR_REPLY: trply = 1'b1;
      DS_END:   if (rd_q) begin tx = 1'b1; be_l = 1'b0; end
      default:  ;
    endcase
  end

  assign ZDAL        = tx ? {6'b0, rdata_q} : {22{1'bz}};
  assign bus.DALtx   = tx;
  assign bus.DALst   = st;
  assign bus.DALbe_L = be_l;
  assign bus.TRPLY   = trply;
  assign bus.iADDR   = addr_q;
  assign bus.iBS7    = bs7_q;
  assign bus.iWDATA  = wdata_q;
  assign bus.iWRITE  = wr_q;
  assign bus.iWBYTE  = wbyte;
endmodule

// File: tb/tb_qslave.sv
// tb_qslave: directed Q-bus cycles against a timeline model of the slave.
`timescale 1ns/1ps
module tb_qslave;
  localparam int INF = 1 << 30;
  localparam int SYN = 2;   // synchronizer depth in cycles

  logic        qclk = 1'b0;
  logic        reset = 1'b1;
  wire  [21:0] ZDAL;
  logic        tb_drv = 1'b0;
  logic [21:0] tb_dal = '0;
  logic [15:0] dev_rdata = '0;
  logic        dev_match;

  qslave_if bus();
  qslave dut (.qclk(qclk), .reset(reset), .ZDAL(ZDAL), .bus(bus));

  assign ZDAL = tb_drv ? tb_dal : {22{1'bz}};
  always #25 qclk = ~qclk;

  // device population: I/O page registers at 17570, 440/441 and 560
  assign dev_match = bus.iBS7 && (bus.iADDR == 13'o17570 || bus.iADDR == 13'o440 ||
                                  bus.iADDR == 13'o441 || bus.iADDR == 13'o560);
  assign bus.iREAD_MATCH  = dev_match;
  assign bus.iWRITE_MATCH = dev_match;
  assign bus.iRDATA       = dev_rdata;

  int cyc = 0;
  always @(posedge qclk) cyc <= cyc + 1;

  // model: each output is active over a cycle interval derived from stimulus times
  int tr_s = INF, tr_e = -1, tx_s = INF, tx_e = -1, be_s = INF, be_e = -1;
  int st_c = -1, wr_c = -1, ad_s = INF, ad_e = -1, wd_s = 0, wb_s = 0;
  logic [15:0] exp_rd = '0, wd_old = '0, wd_new = '0;
  logic [1:0]  wb_old = 2'b11, wb_new = 2'b11;
  logic [12:0] exp_addr = '0;
  logic        exp_bs7 = 1'b0;

  int errors = 0, checks = 0;
  int trply_rises = 0, st_pulses = 0, wr_pulses = 0, tx_cycles = 0;
  logic trply_prev = 1'b0, run_cmp = 1'b0;

  function automatic bit inr(int s, int e, int c);
    return (c >= s) && (c <= e);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // per-cycle compare against the model, sampled mid-cycle
  always @(negedge qclk) if (run_cmp) begin
    chk("TRPLY",   32'(bus.TRPLY),   32'(inr(tr_s, tr_e, cyc)));
    chk("DALtx",   32'(bus.DALtx),   32'(inr(tx_s, tx_e, cyc)));
    chk("DALst",   32'(bus.DALst),   32'(cyc == st_c));
    chk("DALbe_L", 32'(bus.DALbe_L), 32'(!inr(be_s, be_e, cyc)));
    chk("iWRITE",  32'(bus.iWRITE),  32'(cyc == wr_c));
    chk("iWDATA",  32'(bus.iWDATA),  32'(cyc >= wd_s ? wd_new : wd_old));
    chk("iWBYTE",  32'(bus.iWBYTE),  32'(cyc >= wb_s ? wb_new : wb_old));
    if (inr(tx_s, tx_e, cyc)) chk("ZDAL", 32'(ZDAL), 32'({6'b0, exp_rd}));
    if (inr(ad_s, ad_e, cyc)) begin
      chk("iADDR", 32'(bus.iADDR), 32'(exp_addr));
      chk("iBS7",  32'(bus.iBS7),  32'(exp_bs7));
    end
    if (bus.TRPLY && !trply_prev) trply_rises++;
    trply_prev = bus.TRPLY;
    if (bus.DALst)  st_pulses++;
    if (bus.iWRITE) wr_pulses++;
    if (bus.DALtx)  tx_cycles++;
  end

  task automatic tick(int n);
    repeat (n) @(posedge qclk);
    #1;
  endtask

  task automatic wait_reply(string name, output bit ok);
    int n = 0;
    while (!bus.TRPLY && n < 20) begin tick(1); n++; end
    ok = bus.TRPLY;
    if (!ok) chk(name, 32'(bus.TRPLY), 32'd1);
  endtask

  task automatic begin_sync(logic [12:0] addr, logic bs7);
    tb_dal = {9'b0, addr}; tb_drv = 1'b1; bus.ZBS7 = bs7;
    tick(1);
    bus.RSYNC = 1'b1;
    exp_addr = addr; exp_bs7 = bs7; ad_s = cyc + SYN; ad_e = INF;
    tick(3);
    tb_drv = 1'b0; bus.ZBS7 = 1'b0;
  endtask

  task automatic end_sync();
    bus.RSYNC = 1'b0;
    ad_e = cyc + 1;
    tick(5);
  endtask

  task automatic do_read(logic [15:0] rd);
    int d; bit ok;
    dev_rdata = rd; exp_rd = rd;
    bus.RDIN = 1'b1;
    d = cyc + SYN;
    st_c = d + 1; tx_s = d + 1; tx_e = INF; be_s = d + 2; be_e = INF;
    tr_s = d + 3; tr_e = INF;
    wait_reply("rd_reply_timeout", ok);
    if (ok) begin
      chk("rd_latency", 32'(cyc - d), 32'd3);
      chk("rd_zdal", 32'(ZDAL[15:0]), 32'(rd));
    end
    bus.RDIN = 1'b0;
    tr_e = cyc + SYN; tx_e = cyc + SYN + 1; be_e = cyc + SYN + 1;
    tick(4);
  endtask

  task automatic do_write(logic [15:0] data, logic wtbt);
    int d; bit ok;
    tb_dal = {6'b0, data}; tb_drv = 1'b1; bus.ZWTBT = wtbt;
    bus.RDOUT = 1'b1;
    d = cyc + SYN;
    tr_s = d + 1; tr_e = INF; wr_c = d + 1;
    wd_old = (cyc >= wd_s) ? wd_new : wd_old; wd_new = data; wd_s = d + 1;
    wb_old = (cyc >= wb_s) ? wb_new : wb_old; wb_s = d + 1;
`ifdef QSLAVE_BYTE_EN
    wb_new = wtbt ? (exp_addr[0] ? 2'b10 : 2'b01) : 2'b11;
`else
    wb_new = 2'b11;
`endif
    wait_reply("wr_reply_timeout", ok);
    if (ok) chk("wr_latency", 32'(cyc - d), 32'd1);
    bus.RDOUT = 1'b0;
    tr_e = cyc + SYN;
    tick(4);
    tb_drv = 1'b0; bus.ZWTBT = 1'b0;
  endtask

  initial begin
    int r0, w0, s0, t0;
    bit ok;
    bus.ZBS7 = 0; bus.ZWTBT = 0; bus.RSYNC = 0; bus.RDIN = 0; bus.RDOUT = 0;
    run_cmp = 1'b1;
    tick(3);
    chk("rst_iADDR",   32'(bus.iADDR),   32'd0);
    chk("rst_iWBYTE",  32'(bus.iWBYTE),  32'd3);
    chk("rst_DALbe_L", 32'(bus.DALbe_L), 32'd1);
    reset = 1'b0;
    tick(5);

    // DATI 17570, I/O page, device returns 177777
    begin_sync(13'o17570, 1'b1);
    chk("dati_iADDR", 32'(bus.iADDR), 32'(13'o17570));
    chk("dati_iBS7",  32'(bus.iBS7),  32'd1);
    s0 = st_pulses;
    do_read(16'o177777);
    chk("dati_dalst_pulses", 32'(st_pulses - s0), 32'd1);
    end_sync();

    // DATO 440 <- 054321
    begin_sync(13'o440, 1'b1);
    w0 = wr_pulses;
    do_write(16'o054321, 1'b0);
    chk("dato_iWDATA", 32'(bus.iWDATA), 32'(16'o054321));
    chk("dato_iWBYTE", 32'(bus.iWBYTE), 32'd3);
    chk("dato_writes", 32'(wr_pulses - w0), 32'd1);
    end_sync();

    // DATI 400: nobody answers, master would time out
    begin_sync(13'o400, 1'b1);
    r0 = trply_rises; t0 = tx_cycles;
    bus.RDIN = 1'b1;
    tick(12);
    chk("nxm_trply", 32'(trply_rises - r0), 32'd0);
    chk("nxm_daltx", 32'(tx_cycles - t0), 32'd0);
    bus.RDIN = 1'b0;
    end_sync();

    // DATIO 560: read 123456 then write 054545 under one SYNC
    begin_sync(13'o560, 1'b1);
    r0 = trply_rises; w0 = wr_pulses;
    do_read(16'o123456);
    do_write(16'o054545, 1'b0);
    chk("datio_replies", 32'(trply_rises - r0), 32'd2);
    chk("datio_writes",  32'(wr_pulses - w0), 32'd1);
    chk("datio_iWDATA",  32'(bus.iWDATA), 32'(16'o054545));
    end_sync();

    // DATOB to odd byte 441
    begin_sync(13'o441, 1'b1);
    do_write(16'o125000, 1'b1);
`ifdef QSLAVE_BYTE_EN
    chk("datob_iWBYTE", 32'(bus.iWBYTE), 32'd2);
`else
    chk("datob_iWBYTE", 32'(bus.iWBYTE), 32'd3);
`endif
    end_sync();

    // reset pulse while replying to a read; bus stays in SYNC/DIN afterwards
    begin_sync(13'o17570, 1'b1);
    dev_rdata = 16'o111111; exp_rd = 16'o111111;
    bus.RDIN = 1'b1;
    st_c = cyc + SYN + 1; tx_s = cyc + SYN + 1; tx_e = INF;
    be_s = cyc + SYN + 2; be_e = INF; tr_s = cyc + SYN + 3; tr_e = INF;
    wait_reply("rst_reply_timeout", ok);
    reset = 1'b1;
    tr_e = cyc - 1; tx_e = cyc - 1; be_e = cyc - 1; ad_s = INF;
    wd_old = '0; wd_new = '0; wb_old = 2'b11; wb_new = 2'b11;
    #1;
    chk("rst_mid_TRPLY",   32'(bus.TRPLY),   32'd0);
    chk("rst_mid_DALbe_L", 32'(bus.DALbe_L), 32'd1);
    chk("rst_mid_DALtx",   32'(bus.DALtx),   32'd0);
    tick(1);
    reset = 1'b0;
    r0 = trply_rises;
    tick(10);
    chk("rst_no_reply", 32'(trply_rises - r0), 32'd0);
    bus.RDIN = 1'b0;
    end_sync();

    // next SYNC after reset is served normally
    begin_sync(13'o17570, 1'b1);
    do_read(16'o000777);
    end_sync();

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
